// File: rtl/mac_skew_feeder_if.sv
// Host-side bundle for mac_skew_feeder: buffer write port, start/status
// handshake and the skewed lane bus toward the MAC array.
interface mac_skew_feeder_if #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
);
  logic                     wr_en;
  logic [$clog2(DIM)-1:0]   wr_row;
  logic [DIM*BITS_AB-1:0]   wr_data;
  logic                     start;
  logic                     busy;
  logic                     mac_en;
  logic [DIM*BITS_AB-1:0]   a_out;
  logic                     done;

  modport master (
    output wr_en, wr_row, wr_data, start,
    input  busy, mac_en, a_out, done
  );

  modport slave (
    input  wr_en, wr_row, wr_data, start,
    output busy, mac_en, a_out, done
  );
endinterface

// File: rtl/mac_skew_feeder.sv
// Operand feeder for a DIM x DIM systolic MAC array. Holds a DIM x DIM
// buffer and replays it with a diagonal skew: lane r is delayed r cycles,
// so in step t lane r carries M[r][t-r]. A DRAIN phase of DIM zero cycles
// flushes the array before done pulses.
// Build option: FEEDER_TRANSPOSE_EN turns each host write into a column
// write (element k -> M[k][wr_row]) for B-side feeding.
//
// state | meaning
// IDLE  | buffer writable, a_out = 0, waiting for start
// FEED  | 2*DIM-1 steps of skewed buffer data, t = 0..2*DIM-2
// DRAIN | DIM cycles of zeros with mac_en held high
module mac_skew_feeder #(
  parameter int DIM     = 8,
  parameter int BITS_AB = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mac_skew_feeder_if.slave   bus
);
  localparam int TW = $clog2(2 * DIM);
  localparam int RW = $clog2(DIM);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          t_q, t_d;
  logic                   done_q, done_d;
  logic [DIM*BITS_AB-1:0] a_q, a_d;
  logic                   wr_ok;

  logic signed [BITS_AB-1:0] mem [DIM][DIM];

  // Writes are only honoured in IDLE; a simultaneous start is dropped there.
  assign wr_ok = bus.wr_en && (state_q == IDLE);

  // Next-state and step counter; done is flagged on the last DRAIN cycle.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        t_d = '0;
        if (bus.start && !bus.wr_en) state_d = FEED;
      end
      FEED: begin
        if (t_q == TW'(2 * DIM - 2)) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DRAIN: begin
        if (t_q == TW'(DIM - 1)) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Lane data for the upcoming step, so step 0 appears right after start.
  always_comb begin
    a_d = '0;
    if (state_d == FEED) begin
      for (int r = 0; r < DIM; r++) begin
        for (int k = 0; k < DIM; k++) begin
          if (int'(t_d) == r + k) a_d[r*BITS_AB +: BITS_AB] = mem[r][k];
        end
      end
    end
  end

  // FSM state, step counter, done pulse and registered lane outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      a_q     <= a_d;
    end
  end

  // Operand buffer; row write by default, column write in the transpose build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DIM; r++) begin
        for (int k = 0; k < DIM; k++) mem[r][k] <= '0;
      end
    end else if (wr_ok) begin
      for (int r = 0; r < DIM; r++) begin
        for (int k = 0; k < DIM; k++) begin
          if (bus.wr_row == RW'(r)) begin
`ifdef FEEDER_TRANSPOSE_EN
            mem[k][r] <= bus.wr_data[k*BITS_AB +: BITS_AB];
`else
            mem[r][k] <= bus.wr_data[k*BITS_AB +: BITS_AB];
`endif
          end
        end
      end
    end
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.mac_en = (state_q != IDLE);
  assign bus.done   = done_q;
  assign bus.a_out  = a_q;

endmodule
